// File: rtl/state_defs_pkg.sv
// rtl/state_defs_pkg.sv - shared StateDefs: state/instruction enums, field positions, ALU codes
//
// Purpose: one place for the controller state encoding, instruction opcodes,
// instruction field bit positions, ALU op codes and debug to-string helpers.
// Ports: none (package).
package state_defs_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_STORE  = 4'd4,
    ST_LOAD_A = 4'd5,
    ST_LOAD_B = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } inst_t;

  // Instruction field positions
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int ADDR_HI = 11;
  localparam int ADDR_LO = 4;
  localparam int REG_HI  = 3;
  localparam int REG_LO  = 0;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 8;
  localparam int RB_HI   = 7;
  localparam int RB_LO   = 4;
  localparam int RD_HI   = 3;
  localparam int RD_LO   = 0;

  // ALU op codes
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  function automatic string state_to_string(input state_t s);
    case (s)
      ST_INIT:   return "Init";
      ST_FETCH:  return "Fetch";
      ST_DECODE: return "Decode";
      ST_NOOP:   return "Noop";
      ST_STORE:  return "Store";
      ST_LOAD_A: return "Load_A";
      ST_LOAD_B: return "Load_B";
      ST_ADD:    return "Add";
      ST_SUB:    return "Sub";
      ST_HALT:   return "Halt";
      default:   return "Unknown";
    endcase
  endfunction

  // Opcodes 6..15 are not defined and execute as Noop.
  function automatic string inst_to_string(input logic [3:0] op);
    case (op)
      OP_STORE: return "Store";
      OP_LOAD:  return "Load";
      OP_ADD:   return "Add";
      OP_SUB:   return "Sub";
      OP_HALT:  return "Halt";
      default:  return "Noop";
    endcase
  endfunction

endpackage

// File: rtl/control_unit_fetch_regs.sv
// rtl/control_unit_fetch_regs.sv - program counter and instruction register pair
//
// Purpose: holds PC and IR; IR loads the fetched word, PC increments and
// wraps modulo 2^PC_W, both hold when en is low.
// Ports:
//   clk, rst       clock, synchronous active-high reset (PC=0, IR=0)
//   en             advance enable; low holds both registers
//   ir_load        capture ir_next into IR
//   pc_inc         increment PC by one
//   ir_next[15:0]  instruction word to capture
//   pc[PC_W-1:0]   program counter
//   ir[15:0]       instruction register
module fetch_regs #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            ir_load,
  input  logic            pc_inc,
  input  logic [15:0]     ir_next,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else if (en) begin
      if (ir_load) ir <= ir_next;
      // Natural overflow gives the wrap from all-ones back to zero.
      if (pc_inc) pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction controller (fetch/decode/execute FSM)
//
// Purpose: sequences Fetch, Decode and one or two execute states per
// instruction and drives memory/register-file/ALU controls as Moore
// functions of state and IR.
// Ports:
//   clk, rst, en         clock, synchronous active-high reset, advance enable
//   im_data[15:0]        instruction word read at im_addr
//   im_addr, im_rd       program counter and instruction read strobe
//   d_addr, d_rd, d_wr   data-memory address and strobes
//   rf_w_addr/en, rf_ra_addr/en, rf_rb_addr/en   register-file ports
//   rf_s                 write-data select (1 = data memory, 0 = ALU)
//   alu_s0               ALU op (0 pass, 1 add, 2 sub)
//   state_out, halted    current state encoding, Halt indicator
module control_unit
  import state_defs_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int DA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [15:0]     im_data,
  output logic [PC_W-1:0] im_addr,
  output logic            im_rd,
  output logic [DA_W-1:0] d_addr,
  output logic            d_rd,
  output logic            d_wr,
  output logic [3:0]      rf_w_addr,
  output logic [3:0]      rf_ra_addr,
  output logic [3:0]      rf_rb_addr,
  output logic            rf_w_en,
  output logic            rf_ra_en,
  output logic            rf_rb_en,
  output logic            rf_s,
  output logic [2:0]      alu_s0,
  output logic [3:0]      state_out,
  output logic            halted
);

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            in_fetch;

  assign in_fetch = (state == ST_FETCH);

  fetch_regs #(.PC_W(PC_W)) u_fetch_regs (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ir_load (in_fetch),
    .pc_inc  (in_fetch),
    .ir_next (im_data),
    .pc      (pc),
    .ir      (ir)
  );

  always_ff @(posedge clk) begin
    if (rst)     state <= ST_INIT;
    else if (en) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        // IR was captured at the end of Fetch, so it is valid here.
        case (ir[OP_HI:OP_LO])
          OP_STORE: state_next = ST_STORE;
          OP_LOAD:  state_next = ST_LOAD_A;
          OP_ADD:   state_next = ST_ADD;
          OP_SUB:   state_next = ST_SUB;
          OP_HALT:  state_next = ST_HALT;
          default:  state_next = ST_NOOP;
        endcase
      end
      ST_LOAD_A: state_next = ST_LOAD_B;
      ST_NOOP, ST_STORE, ST_LOAD_B, ST_ADD, ST_SUB: state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_INIT;
    endcase
  end

  always_comb begin
    im_rd      = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_addr  = 4'd0;
    rf_ra_addr = 4'd0;
    rf_rb_addr = 4'd0;
    rf_w_en    = 1'b0;
    rf_ra_en   = 1'b0;
    rf_rb_en   = 1'b0;
    rf_s       = 1'b0;
    alu_s0     = ALU_PASS;
    case (state)
      ST_FETCH: im_rd = 1'b1;
      ST_STORE: begin
        d_addr     = DA_W'(ir[ADDR_HI:ADDR_LO]);
        rf_ra_addr = ir[REG_HI:REG_LO];
        rf_ra_en   = 1'b1;
        d_wr       = 1'b1;
      end
      ST_LOAD_A: begin
        d_addr = DA_W'(ir[ADDR_HI:ADDR_LO]);
        d_rd   = 1'b1;
      end
      ST_LOAD_B: begin
        d_addr    = DA_W'(ir[ADDR_HI:ADDR_LO]);
        d_rd      = 1'b1;
        rf_s      = 1'b1;
        rf_w_addr = ir[REG_HI:REG_LO];
        rf_w_en   = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        rf_ra_addr = ir[RA_HI:RA_LO];
        rf_rb_addr = ir[RB_HI:RB_LO];
        rf_ra_en   = 1'b1;
        rf_rb_en   = 1'b1;
        rf_w_addr  = ir[RD_HI:RD_LO];
        rf_w_en    = 1'b1;
        alu_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign im_addr   = pc;
  assign state_out = state;
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking testbench for control_unit
module tb_control_unit;
  import state_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] im_data = 16'h0000;
  logic [6:0]  im_addr;
  logic        im_rd;
  logic [7:0]  d_addr;
  logic        d_rd, d_wr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic        rf_w_en, rf_ra_en, rf_rb_en, rf_s;
  logic [2:0]  alu_s0;
  logic [3:0]  state_out;
  logic        halted;

  int n_checks = 0;
  int n_fails  = 0;

  control_unit #(.PC_W(7), .DA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .im_data    (im_data),
    .im_addr    (im_addr),
    .im_rd      (im_rd),
    .d_addr     (d_addr),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .rf_w_addr  (rf_w_addr),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_en   (rf_ra_en),
    .rf_rb_en   (rf_rb_en),
    .rf_s       (rf_s),
    .alu_s0     (alu_s0),
    .state_out  (state_out),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // ctl = {im_rd, d_rd, d_wr, rf_w_en, rf_ra_en, rf_rb_en, rf_s, halted}
  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [15:0] im;
    logic [3:0]  st;
    logic [6:0]  pc;
    logic [7:0]  da;
    logic [7:0]  ctl;
    logic [3:0]  w;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
  } vec_t;

  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_FETCH = 8'b1000_0000;
  localparam logic [7:0] C_LDA   = 8'b0100_0000;
  localparam logic [7:0] C_LDB   = 8'b0101_0010;
  localparam logic [7:0] C_STORE = 8'b0010_1000;
  localparam logic [7:0] C_ALU   = 8'b0001_1100;
  localparam logic [7:0] C_HALT  = 8'b0000_0001;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input string name, input logic r, input logic e,
                              input logic [15:0] im, input state_t st, input logic [6:0] pc,
                              input logic [7:0] da, input logic [7:0] ctl, input logic [3:0] w,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.im = im; v.st = st; v.pc = pc;
    v.da = da; v.ctl = ctl; v.w = w; v.ra = ra; v.rb = rb; v.alu = alu;
    return v;
  endfunction

  function automatic logic [41:0] act_bits();
    return {state_out, im_addr, d_addr,
            im_rd, d_rd, d_wr, rf_w_en, rf_ra_en, rf_rb_en, rf_s, halted,
            rf_w_addr, rf_ra_addr, rf_rb_addr, alu_s0};
  endfunction

  task automatic check_front();
    vec_t        e;
    logic [41:0] exp_bits;
    logic [41:0] got;
    e = sb.pop_front();
    exp_bits = {e.st, e.pc, e.da, e.ctl, e.w, e.ra, e.rb, e.alu};
    got = act_bits();
    n_checks++;
    if (got !== exp_bits) begin
      n_fails++;
      $display("FAIL %s: got %h required %h (state got %0d required %0d)",
               e.name, got, exp_bits, state_out, e.st);
    end
  endtask

  task automatic run_vec(input vec_t v);
    rst = v.rst;
    en = v.en;
    im_data = v.im;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    // Each record: inputs held across one rising edge, outputs expected after it.
    tbl.push_back(mk("reset",      1, 1, 16'h0000, ST_INIT,   0, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("fetch0",     0, 1, 16'h0000, ST_FETCH,  0, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_add",    0, 1, 16'h3123, ST_DECODE, 1, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("add",        0, 1, 16'h0000, ST_ADD,    1, 8'h00, C_ALU,   3, 1, 2, 1));
    tbl.push_back(mk("fetch1",     0, 1, 16'h0000, ST_FETCH,  1, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_load",   0, 1, 16'h2055, ST_DECODE, 2, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("load_a",     0, 1, 16'h0000, ST_LOAD_A, 2, 8'h05, C_LDA,   0, 0, 0, 0));
    tbl.push_back(mk("load_b",     0, 1, 16'h0000, ST_LOAD_B, 2, 8'h05, C_LDB,   5, 0, 0, 0));
    tbl.push_back(mk("fetch2",     0, 1, 16'h0000, ST_FETCH,  2, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_store",  0, 1, 16'h1A74, ST_DECODE, 3, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("store",      0, 1, 16'h0000, ST_STORE,  3, 8'hA7, C_STORE, 0, 4, 0, 0));
    tbl.push_back(mk("fetch3",     0, 1, 16'h0000, ST_FETCH,  3, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_op9",    0, 1, 16'h9ABC, ST_DECODE, 4, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("noop",       0, 1, 16'h0000, ST_NOOP,   4, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("fetch4",     0, 1, 16'h0000, ST_FETCH,  4, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_sub",    0, 1, 16'h4321, ST_DECODE, 5, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("sub",        0, 1, 16'h0000, ST_SUB,    5, 8'h00, C_ALU,   1, 3, 2, 2));
    tbl.push_back(mk("fetch5",     0, 1, 16'h0000, ST_FETCH,  5, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_add2",   0, 1, 16'h3456, ST_DECODE, 6, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("add2",       0, 1, 16'h0000, ST_ADD,    6, 8'h00, C_ALU,   6, 4, 5, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("add2_hold", 0, 0, 16'hFFFF, ST_ADD,   6, 8'h00, C_ALU,   6, 4, 5, 1));
    tbl.push_back(mk("fetch6",     0, 1, 16'h0000, ST_FETCH,  6, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_halt",   0, 1, 16'h5000, ST_DECODE, 7, 8'h00, C_NONE,  0, 0, 0, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk("halt",     0, 1, 16'h2055, ST_HALT,   7, 8'h00, C_HALT,  0, 0, 0, 0));
    tbl.push_back(mk("rst_halt",   1, 1, 16'h0000, ST_INIT,   0, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("fetch_r",    0, 1, 16'h0000, ST_FETCH,  0, 8'h00, C_FETCH, 0, 0, 0, 0));
    tbl.push_back(mk("dec_load2",  0, 1, 16'h2055, ST_DECODE, 1, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("load_a2",    0, 1, 16'h0000, ST_LOAD_A, 1, 8'h05, C_LDA,   0, 0, 0, 0));
    tbl.push_back(mk("rst_load_a", 1, 0, 16'h0000, ST_INIT,   0, 8'h00, C_NONE,  0, 0, 0, 0));
    tbl.push_back(mk("init_hold",  0, 0, 16'h0000, ST_INIT,   0, 8'h00, C_NONE,  0, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // PC wrap: Noops (op 0) take 3 cycles, so Fetch recurs every 3 edges
    // with PC one higher; after 127 comes 0.
    rst = 1'b1; en = 1'b1; im_data = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state_out !== 4'(ST_FETCH) || im_addr !== 7'd0) begin
      n_fails++;
      $display("FAIL wrap_start: state %0d pc %0d required state 1 pc 0", state_out, im_addr);
    end
    for (int k = 1; k <= 129; k++) begin
      logic [6:0] exp_pc;
      exp_pc = 7'(k % 128);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (state_out !== 4'(ST_FETCH) || im_addr !== exp_pc) begin
        n_fails++;
        $display("FAIL wrap_fetch%0d: state %0d pc %0d required state 1 pc %0d",
                 k, state_out, im_addr, exp_pc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
